// File: rtl/fs_tx_arbiter.sv
// Purpose : shares the FTDI fast-serial FSDI channel between two byte requesters.
//           One requester is granted per frame, FSCTS is honoured, and each
//           granted byte goes out as a 10-bit frame clocked by FSCLK.
// Latency : ready is registered and rises one cycle after an IDLE cycle that
//           sees cts_s=1 and a valid. The start bit follows one cycle later.
//           A frame takes 20*CLK_DIV shift cycles plus a 2*CLK_DIV gap.
// Backpr. : the requester holds valid/data until it sees its one-cycle ready.
//           No grant is made while cts_s=0, so requests wait indefinitely.
//
// Build option:
//   FS_ARB_RR_EN  defined   -> round-robin between the two requesters
//                 undefined -> fixed priority, requester 0 always wins
//
// Parameters:
//   CLK_DIV    wb_clk cycles per FSCLK half-period (1..255)
//   REQ0_DEST  dest bit appended to requester-0 frames
//   REQ1_DEST  dest bit appended to requester-1 frames
//
// Ports:
//   wb_clk, wb_rst_n           system clock, async active-low reset
//   i_req0_valid/i_req0_data   requester 0 (CPU serial port) byte request
//   o_req0_ready               one-cycle accept strobe to requester 0
//   i_req1_valid/i_req1_data   requester 1 (debug port) byte request
//   o_req1_ready               one-cycle accept strobe to requester 1
//   i_fscts                    FTDI clear-to-send, asynchronous to wb_clk
//   o_fsclk, o_fsdi            fast-serial clock and data to the FTDI
//   o_busy                     high from accept until the end of the gap

module fs_tx_arbiter #(
   parameter int unsigned CLK_DIV   = 4,
   parameter logic        REQ0_DEST = 1'b0,
   parameter logic        REQ1_DEST = 1'b1
) (
   input  logic       wb_clk,
   input  logic       wb_rst_n,
   input  logic       i_req0_valid,
   input  logic [7:0] i_req0_data,
   output logic       o_req0_ready,
   input  logic       i_req1_valid,
   input  logic [7:0] i_req1_data,
   output logic       o_req1_ready,
   input  logic       i_fscts,
   output logic       o_fsclk,
   output logic       o_fsdi,
   output logic       o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Terminal counts for one FSCLK half-period and for the inter-frame gap.
   localparam logic [8:0] LP_HALF_M1 = 9'(CLK_DIV - 1);
   localparam logic [8:0] LP_GAP_M1  = 9'(2 * CLK_DIV - 1);
   localparam logic [3:0] LP_LAST_BIT = 4'd9;

   // ------------------------------------------------------------------
   // FSCTS synchronizer
   // ------------------------------------------------------------------
   logic r_cts_meta;
   logic r_cts_s;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_cts_meta <= 1'b0;
         r_cts_s    <= 1'b0;
      end else begin
         r_cts_meta <= i_fscts;
         r_cts_s    <= r_cts_meta;
      end
   end

   // ------------------------------------------------------------------
   // Arbitration (only consulted while in IDLE)
   // ------------------------------------------------------------------
   state_t      r_state;
   logic        r_load;
   logic [8:0]  r_div_cnt;
   logic        r_phase;
   logic [3:0]  r_bit_cnt;
   logic [9:0]  r_shift;
   logic        r_fsclk;
   logic        r_fsdi;
   logic        r_req0_ready;
   logic        r_req1_ready;
   logic        r_busy;

   logic        w_req_any;
   logic        w_pick1;
   logic        w_grant;

   assign w_req_any = i_req0_valid | i_req1_valid;

`ifdef FS_ARB_RR_EN
   // r_rr_favour1 set means requester 1 wins a tie. It moves on the
   // accept strobe, so it always points away from the last winner.
   logic r_rr_favour1;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_rr_favour1 <= 1'b0;
      end else if (r_req0_ready) begin
         r_rr_favour1 <= 1'b1;
      end else if (r_req1_ready) begin
         r_rr_favour1 <= 1'b0;
      end
   end

   assign w_pick1 = i_req1_valid & (~i_req0_valid | r_rr_favour1);
`else
   assign w_pick1 = ~i_req0_valid;
`endif

   assign w_grant = (r_state == ST_IDLE) & r_cts_s & w_req_any;

   // ------------------------------------------------------------------
   // Frame FSM
   // r_shift holds {dest, D7..D0, start}; bit 0 is always the bit on the
   // wire next. r_load marks the accept cycle: ready is high there and the
   // line is still idle, the start bit is driven on the following cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state      <= ST_IDLE;
         r_load       <= 1'b0;
         r_div_cnt    <= 9'd0;
         r_phase      <= 1'b0;
         r_bit_cnt    <= 4'd0;
         r_shift      <= 10'h3FF;
         r_fsclk      <= 1'b0;
         r_fsdi       <= 1'b1;
         r_req0_ready <= 1'b0;
         r_req1_ready <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_fsclk <= 1'b0;
               r_fsdi  <= 1'b1;
               if (w_grant) begin
                  r_state      <= ST_SHIFT;
                  r_load       <= 1'b1;
                  r_busy       <= 1'b1;
                  r_req0_ready <= ~w_pick1;
                  r_req1_ready <= w_pick1;
                  if (w_pick1) begin
                     r_shift <= {REQ1_DEST, i_req1_data, 1'b0};
                  end else begin
                     r_shift <= {REQ0_DEST, i_req0_data, 1'b0};
                  end
               end
            end

            ST_SHIFT: begin
               if (r_load) begin
                  // Accept cycle ends: drop ready and present the start bit
                  // at the beginning of its low phase.
                  r_load       <= 1'b0;
                  r_req0_ready <= 1'b0;
                  r_req1_ready <= 1'b0;
                  r_fsdi       <= r_shift[0];
                  r_fsclk      <= 1'b0;
                  r_div_cnt    <= 9'd0;
                  r_phase      <= 1'b0;
                  r_bit_cnt    <= 4'd0;
               end else if (r_div_cnt == LP_HALF_M1) begin
                  r_div_cnt <= 9'd0;
                  if (!r_phase) begin
                     // Low phase done: rising FSCLK, data already stable.
                     r_phase <= 1'b1;
                     r_fsclk <= 1'b1;
                  end else begin
                     r_phase <= 1'b0;
                     r_fsclk <= 1'b0;
                     if (r_bit_cnt == LP_LAST_BIT) begin
                        r_state <= ST_GAP;
                        r_fsdi  <= 1'b1;
                     end else begin
                        // Data only changes together with the falling edge.
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_shift   <= {1'b1, r_shift[9:1]};
                        r_fsdi    <= r_shift[1];
                     end
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 9'd1;
               end
            end

            ST_GAP: begin
               // Lets the FTDI's post-frame CTS drop reach cts_s before the
               // next grant decision.
               r_fsclk <= 1'b0;
               r_fsdi  <= 1'b1;
               if (r_div_cnt == LP_GAP_M1) begin
                  r_div_cnt <= 9'd0;
                  r_state   <= ST_IDLE;
                  r_busy    <= 1'b0;
               end else begin
                  r_div_cnt <= r_div_cnt + 9'd1;
               end
            end

            default: begin
               r_state      <= ST_IDLE;
               r_load       <= 1'b0;
               r_fsclk      <= 1'b0;
               r_fsdi       <= 1'b1;
               r_req0_ready <= 1'b0;
               r_req1_ready <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign o_req0_ready = r_req0_ready;
   assign o_req1_ready = r_req1_ready;
   assign o_fsclk      = r_fsclk;
   assign o_fsdi       = r_fsdi;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_fs_tx_arbiter.sv
// Purpose : self-checking bench for fs_tx_arbiter with CLK_DIV=4.
// Latency : expects ready one cycle after a seen request, 88 cycles start-to-idle.
// Backpr. : requesters hold valid/data until ready; FSCTS gates grants.

module tb_fs_tx_arbiter;

   localparam int CLK_DIV   = 4;
   localparam int FRAME_CYC = 22 * CLK_DIV;       // start bit to IDLE
   localparam int B2B_CYC   = 22 * CLK_DIV + 2;   // ready-to-ready spacing

   logic       wb_clk = 1'b0;
   logic       wb_rst_n = 1'b0;
   logic       i_req0_valid = 1'b0;
   logic [7:0] i_req0_data = 8'h00;
   logic       i_req1_valid = 1'b0;
   logic [7:0] i_req1_data = 8'h00;
   logic       i_fscts = 1'b1;
   logic       o_req0_ready;
   logic       o_req1_ready;
   logic       o_fsclk;
   logic       o_fsdi;
   logic       o_busy;

   fs_tx_arbiter #(
      .CLK_DIV   (CLK_DIV),
      .REQ0_DEST (1'b0),
      .REQ1_DEST (1'b1)
   ) u_dut (
      .wb_clk       (wb_clk),
      .wb_rst_n     (wb_rst_n),
      .i_req0_valid (i_req0_valid),
      .i_req0_data  (i_req0_data),
      .o_req0_ready (o_req0_ready),
      .i_req1_valid (i_req1_valid),
      .i_req1_data  (i_req1_data),
      .o_req1_ready (o_req1_ready),
      .i_fscts      (i_fscts),
      .o_fsclk      (o_fsclk),
      .o_fsdi       (o_fsdi),
      .o_busy       (o_busy)
   );

   always #5 wb_clk = ~wb_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: frames as transmitted, bit i = i-th bit on the wire.
   logic [9:0] exp_frame_q[$];
   int         exp_grant_q[$];

   int         cyc = 0;
   int         edges = 0;
   int         rdy_cnt0 = 0;
   int         rdy_cnt1 = 0;
   int         last_rdy_cyc = -1;
   int         rdy_gap_q[$];
   logic       prev_fsclk = 1'b0;
   logic       prev_rdy = 1'b0;
   logic [9:0] rx = 10'h000;
   int         rx_cnt = 0;
   int         mon_id;
   logic [9:0] mon_exp;

   // Output monitor: captures FSDI on FSCLK rising edges and accept strobes.
   always @(negedge wb_clk) begin
      cyc++;
      if (!wb_rst_n) begin
         rx_cnt     = 0;
         prev_fsclk = 1'b0;
         prev_rdy   = 1'b0;
      end else begin
         if (o_fsclk && !prev_fsclk) begin
            edges++;
            rx[rx_cnt] = o_fsdi;
            rx_cnt++;
            if (rx_cnt == 10) begin
               rx_cnt = 0;
               check("frame_expected", 32'(exp_frame_q.size() > 0), 1);
               if (exp_frame_q.size() > 0) begin
                  mon_exp = exp_frame_q.pop_front();
                  check("frame_bits", 32'(rx), 32'(mon_exp));
               end
            end
         end
         prev_fsclk = o_fsclk;

         if (o_req0_ready || o_req1_ready) begin
            check("rdy_both", 32'(o_req0_ready & o_req1_ready), 0);
            check("rdy_width", 32'(prev_rdy), 0);
            check("busy_with_rdy", 32'(o_busy), 1);
            mon_id = o_req1_ready ? 1 : 0;
            if (mon_id == 1) rdy_cnt1++; else rdy_cnt0++;
            check("grant_expected", 32'(exp_grant_q.size() > 0), 1);
            if (exp_grant_q.size() > 0) begin
               check("grant_id", 32'(mon_id), 32'(exp_grant_q.pop_front()));
            end
            if (last_rdy_cyc >= 0) rdy_gap_q.push_back(cyc - last_rdy_cyc);
            last_rdy_cyc = cyc;
         end
         prev_rdy = o_req0_ready | o_req1_ready;
      end
   end

   task automatic set_req(input int id, input logic v, input logic [7:0] d);
      if (id == 0) begin
         i_req0_valid = v;
         i_req0_data  = d;
      end else begin
         i_req1_valid = v;
         i_req1_data  = d;
      end
   endtask

   task automatic wait_rdy(input int id, input int budget, output int cycles);
      logic seen;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < budget) begin
         @(negedge wb_clk);
         cycles++;
         seen = (id == 1) ? o_req1_ready : o_req0_ready;
      end
      check("rdy_within_budget", 32'(seen), 1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (o_busy && n < budget) begin
         @(negedge wb_clk);
         n++;
      end
      check("idle_within_budget", 32'(o_busy), 0);
   endtask

   // Requester model: holds valid for n accepts of the same byte.
   task automatic send(input int id, input logic [7:0] d, input int n);
      int c;
      set_req(id, 1'b1, d);
      for (int k = 0; k < n; k++) begin
         wait_rdy(id, 3000, c);
      end
      set_req(id, 1'b0, d);
   endtask

   initial begin
      int c;
      int bad;
      int e0;
      int r0;

      // ---------------- reset values ----------------
      repeat (3) @(negedge wb_clk);
      check("rst_fsclk", 32'(o_fsclk), 0);
      check("rst_fsdi", 32'(o_fsdi), 1);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_rdy0", 32'(o_req0_ready), 0);
      check("rst_rdy1", 32'(o_req1_ready), 0);
      wb_rst_n = 1'b1;

      // ---------------- idle levels ----------------
      bad = 0;
      repeat (200) begin
         @(negedge wb_clk);
         if (o_fsclk !== 1'b0 || o_fsdi !== 1'b1 || o_busy !== 1'b0) bad++;
      end
      check("idle_levels", 32'(bad), 0);
      check("idle_edges", 32'(edges), 0);

      // ---------------- single frame 0xA5 ----------------
      e0 = edges;
      r0 = rdy_cnt0;
      exp_frame_q.push_back({1'b0, 8'hA5, 1'b0});
      exp_grant_q.push_back(0);
      set_req(0, 1'b1, 8'hA5);
      wait_rdy(0, 50, c);
      check("accept_latency", 32'(c), 1);
      set_req(0, 1'b0, 8'h00);
      @(negedge wb_clk);
      check("start_bit", 32'(o_fsdi), 0);
      check("start_fsclk_low", 32'(o_fsclk), 0);
      c = 0;
      while (o_busy && c < 500) begin
         @(negedge wb_clk);
         c++;
      end
      check("frame_cycles", 32'(c), 32'(FRAME_CYC));
      check("single_edges", 32'(edges - e0), 10);
      check("single_rdy_pulses", 32'(rdy_cnt0 - r0), 1);

      // ---------------- flow control ----------------
      i_fscts = 1'b0;
      repeat (5) @(negedge wb_clk);
      e0 = edges;
      r0 = rdy_cnt1;
      exp_frame_q.push_back({1'b1, 8'h3C, 1'b0});
      exp_grant_q.push_back(1);
      set_req(1, 1'b1, 8'h3C);
      repeat (500) @(negedge wb_clk);
      check("cts_low_rdy", 32'(rdy_cnt1 - r0), 0);
      check("cts_low_edges", 32'(edges - e0), 0);
      i_fscts = 1'b1;
      wait_rdy(1, 50, c);
      check("cts_latency", 32'(c), 3);
      set_req(1, 1'b0, 8'h00);
      wait_idle(500);

      // ---------------- CTS drop mid-frame ----------------
      exp_frame_q.push_back({1'b0, 8'h5A, 1'b0});
      exp_grant_q.push_back(0);
      set_req(0, 1'b1, 8'h5A);
      wait_rdy(0, 50, c);
      set_req(0, 1'b0, 8'h00);
      e0 = edges;
      repeat (1 + 3 * 2 * CLK_DIV + 3) @(negedge wb_clk);
      i_fscts = 1'b0;
      exp_frame_q.push_back({1'b1, 8'hC3, 1'b0});
      exp_grant_q.push_back(1);
      set_req(1, 1'b1, 8'hC3);
      wait_idle(500);
      check("cts_drop_edges", 32'(edges - e0), 10);
      r0 = rdy_cnt1;
      repeat (100) @(negedge wb_clk);
      check("cts_drop_no_grant", 32'(rdy_cnt1 - r0), 0);
      i_fscts = 1'b1;
      wait_rdy(1, 50, c);
      check("cts_resume_latency", 32'(c), 3);
      set_req(1, 1'b0, 8'h00);
      wait_idle(500);

      // ---------------- reset mid-frame ----------------
      // 0x6C has D4=0, so bit 5 drives FSDI low during its high phase.
      exp_frame_q.push_back({1'b0, 8'h6C, 1'b0});
      exp_grant_q.push_back(0);
      exp_grant_q.push_back(0);
      set_req(0, 1'b1, 8'h6C);
      wait_rdy(0, 50, c);
      repeat (1 + 5 * 2 * CLK_DIV + CLK_DIV + 1) @(negedge wb_clk);
      check("pre_rst_fsclk", 32'(o_fsclk), 1);
      check("pre_rst_fsdi", 32'(o_fsdi), 0);
      wb_rst_n = 1'b0;
      #1;
      check("rst_mid_fsclk", 32'(o_fsclk), 0);
      check("rst_mid_fsdi", 32'(o_fsdi), 1);
      check("rst_mid_busy", 32'(o_busy), 0);
      repeat (3) @(negedge wb_clk);
      wb_rst_n = 1'b1;
      wait_rdy(0, 50, c);
      check("rst_reissue_latency", 32'(c), 3);
      set_req(0, 1'b0, 8'h00);
      wait_idle(500);

      // ---------------- arbitration ----------------
      wb_rst_n = 1'b0;
      repeat (2) @(negedge wb_clk);
      wb_rst_n = 1'b1;
      repeat (3) @(negedge wb_clk);
      rdy_gap_q.delete();
      last_rdy_cyc = -1;
`ifdef FS_ARB_RR_EN
      for (int k = 0; k < 2; k++) begin
         exp_frame_q.push_back({1'b0, 8'h11, 1'b0});
         exp_grant_q.push_back(0);
         exp_frame_q.push_back({1'b1, 8'h22, 1'b0});
         exp_grant_q.push_back(1);
      end
      fork
         send(0, 8'h11, 2);
         send(1, 8'h22, 2);
      join
`else
      for (int k = 0; k < 4; k++) begin
         exp_frame_q.push_back({1'b0, 8'h11, 1'b0});
         exp_grant_q.push_back(0);
      end
      exp_frame_q.push_back({1'b1, 8'h22, 1'b0});
      exp_grant_q.push_back(1);
      fork
         send(0, 8'h11, 4);
         send(1, 8'h22, 1);
      join
`endif
      wait_idle(500);
      check("b2b_gap_count", 32'(rdy_gap_q.size() >= 3), 1);
      for (int k = 0; k < 3 && k < rdy_gap_q.size(); k++) begin
         check("b2b_gap", 32'(rdy_gap_q[k]), 32'(B2B_CYC));
      end

      // ---------------- drain ----------------
      repeat (20) @(negedge wb_clk);
      check("frames_left", 32'(exp_frame_q.size()), 0);
      check("grants_left", 32'(exp_grant_q.size()), 0);
      check("partial_frame", 32'(rx_cnt), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fs_tx_arbiter.md
# fs_tx_arbiter

Transmit-side controller for the FTDI fast opto-isolated serial link (FSDI/FSCLK out, FSCTS in) on the CYC1000 SoC. It shares the single FSDI channel between two byte requesters: requester 0 is the CPU serial port and requester 1 is the debug port. It grants one requester per frame and honours FSCTS flow control. For each granted byte it generates FSCLK and serializes a 10-bit fast-serial frame.

## Interface
- CLK_DIV, 4: wb_clk cycles per FSCLK half-period; legal range 1..255.
- REQ0_DEST, 1'b0: source/destination bit appended to requester-0 frames (0 = port A, 1 = port B).
- REQ1_DEST, 1'b1: source/destination bit appended to requester-1 frames.

Ports:
- wb_clk  in  1  system clock.
- wb_rst_n  in  1  asynchronous, active-low reset.
- i_req0_valid  in  1  requester 0 has a byte.
- i_req0_data  in  8  requester 0 byte.
- o_req0_ready  out  1  one-cycle accept strobe to requester 0.
- i_req1_valid  in  1  requester 1 has a byte.
- i_req1_data  in  8  requester 1 byte.
- o_req1_ready  out  1  one-cycle accept strobe to requester 1.
- i_fscts  in  1  FTDI clear-to-send; asynchronous to wb_clk.
- o_fsclk  out  1  fast-serial clock to FTDI.
- o_fsdi  out  1  fast-serial data to FTDI.
- o_busy  out  1  high from accept until the end of the inter-frame gap.

## Operation
- i_fscts passes through a 2-flop synchronizer to give cts_s. Only cts_s is used internally.
- The state machine has three states: IDLE, SHIFT and GAP.
- **IDLE → SHIFT:** taken when cts_s=1 and at least one valid is high.
  - The winner's ready pulses for exactly one cycle, and that cycle is the accept.
  - Data and the dest bit are latched on the accept.
- **Arbitration:** see Configuration. It is evaluated only in IDLE.
- **Frame, transmitted in order, 10 bits:**
  - start bit 0;
  - data bits D0..D7, LSB first;
  - the dest bit.
- **Each bit period is 2×CLK_DIV cycles:**
  - o_fsclk is low for the first CLK_DIV cycles, then high for CLK_DIV cycles.
  - o_fsdi changes only at the start of the low phase, so the FTDI samples a stable bit on the FSCLK rising edge.
- **SHIFT → GAP:** taken after the 10th bit's high phase completes. o_fsclk returns low and o_fsdi returns high.
- **GAP → IDLE:** taken after 2×CLK_DIV cycles. The gap guarantees that FTDI's post-frame CTS deassertion reaches cts_s before the next grant.
- **Idle levels:** o_fsclk=0, o_fsdi=1.
- **Requester rule:** valid and data must be held stable until ready is seen. A valid withdrawn before the accept has no effect.

## Timing
- **Reset values:** o_fsclk=0, o_fsdi=1, o_req0_ready=0, o_req1_ready=0, o_busy=0, state=IDLE, RR pointer favours requester 0, synchronizer flops=0.
- **Reset asserted mid-frame:** all outputs go to reset values immediately (asynchronously). The in-flight byte is lost, and no ready is re-issued for it.
- **Accept latency:**
  - With valid already high and cts_s=1, ready is asserted combinationally-free, i.e. registered: ready goes high in the cycle after the IDLE cycle in which the request is seen.
  - o_busy rises in the same cycle as ready.
  - The start bit drives o_fsdi=0 in the cycle after ready.
- **Frame duration:** 20×CLK_DIV cycles for SHIFT plus 2×CLK_DIV cycles for GAP. With CLK_DIV=4 this is 80+8=88 cycles from the first start-bit cycle to IDLE.
- **i_fscts latency:** i_fscts reaches the grant decision after 2 cycles.
- **CTS low in IDLE:** no grant is made; requests wait indefinitely.
- **CTS drop mid-frame:** ignored; the frame completes.
- **Back-to-back:** the minimum request-to-request spacing is 1 + 22×CLK_DIV + 1 cycles.

## Configuration
- **FS_ARB_RR_EN defined:** round-robin arbitration.
  - When both requesters are valid, the one not granted last wins.
  - The pointer updates only on an accept.
  - A lone valid requester always wins.
- **FS_ARB_RR_EN undefined:** fixed priority; requester 0 always wins when valid. The pointer logic is not built.

## Test plan
- **Reset idle:** reset released, no requests, i_fscts=1 → o_fsclk=0, o_fsdi=1, o_busy=0 for 200 cycles.
- **Single frame:** CLK_DIV=4, requester 0 sends 0xA5, REQ0_DEST=0 → exactly one ready pulse. Frame sampled on FSCLK rising edges reads 0,1,0,1,0,0,1,0,1,0. There are exactly 10 FSCLK rising edges, and IDLE is reached 88 cycles after the start bit.
- **Flow control:** i_fscts=0 with requester 1 valid for 500 cycles → no ready pulse and no FSCLK edges. Raise i_fscts → ready pulse 3 cycles later; the frame carries dest bit 1.
- **Arbitration:** both requesters valid continuously, 0x11 and 0x22 →
  - with FS_ARB_RR_EN, grants alternate 0,1,0,1;
  - without it, only requester 0 is granted for 4 frames.
- **Mid-frame CTS drop:** i_fscts falls during bit 3 → frame finishes all 10 bits; the next grant waits for cts_s=1.
- **Reset mid-frame:** assert wb_rst_n=0 during bit 5 → o_fsclk=0 and o_fsdi=1 in the same cycle. After release, with the request still valid, a fresh full frame of the same byte is sent after a new ready pulse.
